// File: rtl/key_search_pkg.sv
// Shared types and default sizing for the multi-core RC4 key-space search.
package key_search_pkg;

    localparam int unsigned NUM_CORES  = 4;
    localparam int unsigned KEY_WIDTH  = 24;
    localparam int unsigned BLOCK_BITS = 16;
    localparam logic [KEY_WIDTH-1:0] KEY_LIMIT = 24'h3FFFFF;
    localparam int unsigned NUM_BLOCKS = (32'(KEY_LIMIT) + 32'd1) >> BLOCK_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StFound,
        StExhausted
    } key_search_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after i_ptr,
// wrapping around so the pointer's own index has the lowest priority.
module rr_arbiter #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0]                                    i_req,
    input  logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0]    i_ptr,
    output logic [NUM_CORES-1:0]                                    o_grant,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0]    o_idx,
    output logic                                                    o_valid
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [31:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            w_pos = (32'(i_ptr) + k) % NUM_CORES;
            if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
                o_valid                   = 1'b1;
                o_idx                     = w_pos[IDX_W-1:0];
                o_grant[w_pos[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_search_dispatcher.sv
// Key-space controller: hands out key blocks to idle cores, latches the first
// solution, broadcasts stop and reports exhaustion of the key space.
module key_search_dispatcher
    import key_search_pkg::*;
#(
    parameter int unsigned           NUM_CORES  = key_search_pkg::NUM_CORES,
    parameter int unsigned           KEY_WIDTH  = key_search_pkg::KEY_WIDTH,
    parameter int unsigned           BLOCK_BITS = key_search_pkg::BLOCK_BITS,
    parameter logic [KEY_WIDTH-1:0]  KEY_LIMIT  = key_search_pkg::KEY_LIMIT
) (
    input  logic                                                 CLOCK_50,
    input  logic                                                 reset_n,
    input  logic                                                 go,
    input  logic [NUM_CORES-1:0]                                 core_req,
    input  logic [NUM_CORES-1:0]                                 core_solved,
    input  logic [NUM_CORES*KEY_WIDTH-1:0]                       core_key,
    output logic [NUM_CORES-1:0]                                 core_grant,
    output logic [KEY_WIDTH-1:0]                                 core_base_key,
    output logic                                                 stop_all,
    output logic                                                 found,
    output logic [KEY_WIDTH-1:0]                                 found_key,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] found_core,
    output logic                                                 exhausted,
    output logic                                                 busy,
    output logic [KEY_WIDTH-BLOCK_BITS:0]                        blocks_issued
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = KEY_WIDTH - BLOCK_BITS + 1;
    localparam logic [KEY_WIDTH:0] BLOCK_STEP = (KEY_WIDTH+1)'(1) << BLOCK_BITS;
    localparam logic [IDX_W-1:0]   PTR_INIT   = IDX_W'(NUM_CORES - 1);

    key_search_state_t r_state, w_state_next;

    // One bit wider than a key so the increment past the last block cannot wrap.
    logic [KEY_WIDTH:0]      r_next_base;
    logic [KEY_WIDTH:0]      w_next_base_inc;
    logic [IDX_W-1:0]        r_ptr;
    logic [NUM_CORES-1:0]    r_grant;
    logic [KEY_WIDTH-1:0]    r_base_key;
    logic [KEY_WIDTH-1:0]    r_found_key;
    logic [IDX_W-1:0]        r_found_core;
    logic [CNT_W-1:0]        r_blocks;

    logic [NUM_CORES-1:0]    w_req_masked;
    logic [NUM_CORES-1:0]    w_arb_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_arb_valid;
    logic                    w_any_solved;
    logic [IDX_W-1:0]        w_win_idx;
    logic [KEY_WIDTH-1:0]    w_win_key;
    logic                    w_do_start;
    logic                    w_do_grant;
    logic                    w_do_solve;

    // A core is still seeing its grant pulse this cycle, so its req is not trusted yet.
    assign w_req_masked    = core_req & ~r_grant;
    assign w_next_base_inc = r_next_base + BLOCK_STEP;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_arbiter (
        .i_req   (w_req_masked),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_any_solved = |core_solved;
        w_win_idx    = '0;
        w_win_key    = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (core_solved[i]) begin
                w_win_idx = IDX_W'(i);
                w_win_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_do_start   = 1'b0;
        w_do_grant   = 1'b0;
        w_do_solve   = 1'b0;
        unique case (r_state)
            StIdle, StFound, StExhausted: begin
                if (go) begin
                    w_state_next = StRun;
                    w_do_start   = 1'b1;
                end
            end
            StRun: begin
                if (w_any_solved) begin
                    w_state_next = StFound;
                    w_do_solve   = 1'b1;
                end else if (w_arb_valid) begin
                    w_do_grant = 1'b1;
                    if (w_next_base_inc > {1'b0, KEY_LIMIT}) begin
                        w_state_next = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_any_solved) begin
                    w_state_next = StFound;
                    w_do_solve   = 1'b1;
                end else if (&core_req) begin
                    w_state_next = StExhausted;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_next_base  <= '0;
            r_ptr        <= PTR_INIT;
            r_grant      <= '0;
            r_base_key   <= '0;
            r_found_key  <= '0;
            r_found_core <= '0;
            r_blocks     <= '0;
        end else begin
            r_grant    <= '0;
            r_base_key <= '0;
            if (w_do_start) begin
                // Pointer returns to its reset value so core 0 has first priority.
                r_next_base  <= '0;
                r_ptr        <= PTR_INIT;
                r_blocks     <= '0;
                r_found_key  <= '0;
                r_found_core <= '0;
            end
            if (w_do_grant) begin
                r_grant     <= w_arb_grant;
                r_base_key  <= r_next_base[KEY_WIDTH-1:0];
                r_next_base <= w_next_base_inc;
                r_blocks    <= r_blocks + CNT_W'(1);
                r_ptr       <= w_arb_idx;
            end
            if (w_do_solve) begin
                r_found_key  <= w_win_key;
                r_found_core <= w_win_idx;
            end
        end
    end

    assign core_grant    = r_grant;
    assign core_base_key = r_base_key;
    assign found         = (r_state == StFound);
    assign exhausted     = (r_state == StExhausted);
    assign stop_all      = found | exhausted;
    assign busy          = (r_state == StRun) || (r_state == StDrain);
    assign found_key     = r_found_key;
    assign found_core    = r_found_core;
    assign blocks_issued = r_blocks;

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Directed bench for key_search_dispatcher with a grant scoreboard and simple core models.
module tb_key_search_dispatcher;
    import key_search_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam int unsigned CNT_W = KEY_WIDTH - BLOCK_BITS + 1;

    logic                           CLOCK_50;
    logic                           reset_n;
    logic                           go;
    logic [NUM_CORES-1:0]           core_req;
    logic [NUM_CORES-1:0]           core_solved;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic [NUM_CORES-1:0]           core_grant;
    logic [KEY_WIDTH-1:0]           core_base_key;
    logic                           stop_all;
    logic                           found;
    logic [KEY_WIDTH-1:0]           found_key;
    logic [IDX_W-1:0]               found_core;
    logic                           exhausted;
    logic                           busy;
    logic [CNT_W-1:0]               blocks_issued;

    key_search_dispatcher dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .go            (go),
        .core_req      (core_req),
        .core_solved   (core_solved),
        .core_key      (core_key),
        .core_grant    (core_grant),
        .core_base_key (core_base_key),
        .stop_all      (stop_all),
        .found         (found),
        .found_key     (found_key),
        .found_core    (found_core),
        .exhausted     (exhausted),
        .busy          (busy),
        .blocks_issued (blocks_issued)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int unsigned          core;
        logic [KEY_WIDTH-1:0] base;
    } exp_t;

    exp_t                 exp_q[$];
    int                   checks;
    int                   errors;
    logic [NUM_CORES-1:0] prev_grant;
    logic [NUM_CORES-1:0] hold;
    logic [NUM_CORES-1:0] auto_en;
    logic [NUM_CORES-1:0] auto_req;
    int                   auto_cnt[NUM_CORES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_req();
        core_req = hold | (auto_en & auto_req);
    endtask

    task automatic push_exp(input int unsigned core, input int unsigned blk);
        exp_t e;
        e.core = core;
        e.base = KEY_WIDTH'(blk << BLOCK_BITS);
        exp_q.push_back(e);
    endtask

    task automatic push_rr(input int unsigned count);
        for (int unsigned k = 0; k < count; k++) push_exp(k % NUM_CORES, k);
    endtask

    // Advance one cycle, score any grant, then let the modelled cores react.
    task automatic tick();
        exp_t                 e;
        logic [NUM_CORES-1:0] eg;
        @(posedge CLOCK_50);
        #1;
        if (core_grant !== '0) begin
            check("grant_expected", 32'(exp_q.size() != 0), 32'd1);
            check("no_back_to_back", 32'(core_grant & prev_grant), 32'd0);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                eg = NUM_CORES'(1) << e.core;
                check("grant_core", 32'(core_grant), 32'(eg));
                check("grant_base", 32'(core_base_key), 32'(e.base));
            end
        end
        prev_grant = core_grant;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (core_grant[i]) begin
                auto_req[i] = 1'b0;
                auto_cnt[i] = 2;
            end else if (auto_cnt[i] != 0) begin
                auto_cnt[i]--;
                if (auto_cnt[i] == 0) auto_req[i] = 1'b1;
            end
        end
        drive_req();
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_blocks(input int unsigned target, input int unsigned budget);
        for (int unsigned c = 0; c < budget; c++) begin
            tick();
            if (blocks_issued == CNT_W'(target)) break;
        end
        check("wait_blocks", 32'(blocks_issued), target);
    endtask

    task automatic set_key(input int unsigned idx, input logic [KEY_WIDTH-1:0] k);
        core_key[idx*KEY_WIDTH +: KEY_WIDTH] = k;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(core_grant), 32'd0);
        check({tag, "_base"}, 32'(core_base_key), 32'd0);
        check({tag, "_stop"}, 32'(stop_all), 32'd0);
        check({tag, "_found"}, 32'(found), 32'd0);
        check({tag, "_fkey"}, 32'(found_key), 32'd0);
        check({tag, "_fcore"}, 32'(found_core), 32'd0);
        check({tag, "_exh"}, 32'(exhausted), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_blocks"}, 32'(blocks_issued), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        hold    = '0;
        auto_en = '0;
        drive_req();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        go          = 1'b0;
        core_solved = '0;
        core_key    = '0;
        hold        = '0;
        auto_en     = '0;
        auto_req    = '0;
        prev_grant  = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) auto_cnt[i] = 0;
        drive_req();

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Exhaustion: core 0 alone, re-requesting two cycles after each grant
        for (int unsigned k = 0; k < NUM_BLOCKS; k++) push_exp(0, k);
        auto_en     = 4'b0001;
        auto_req[0] = 1'b1;
        drive_req();
        pulse_go();
        wait_blocks(64, 400);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_not_exh", 32'(exhausted), 32'd0);
        check("drain_no_stop", 32'(stop_all), 32'd0);
        auto_en = '0;
        hold    = '1;
        drive_req();
        tick();
        check("exh_flag", 32'(exhausted), 32'd1);
        check("exh_stop", 32'(stop_all), 32'd1);
        check("exh_blocks", 32'(blocks_issued), 32'd64);
        check("exh_busy", 32'(busy), 32'd0);
        check("exh_queue", 32'(exp_q.size()), 32'd0);

        // Round-robin, restarted from EXHAUSTED; go mid-run must be ignored
        push_rr(8);
        pulse_go();
        check("restart_exh_clr", 32'(exhausted), 32'd0);
        check("restart_stop_clr", 32'(stop_all), 32'd0);
        check("restart_blocks", 32'(blocks_issued), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_blocks(4, 20);
        pulse_go();
        wait_blocks(8, 20);
        hold = '0;
        drive_req();
        repeat (3) tick();
        check("rr_queue", 32'(exp_q.size()), 32'd0);
        check("rr_blocks", 32'(blocks_issued), 32'd8);

        // Single solution after 10 grants; requests stay high so a grant candidate competes
        do_reset();
        push_rr(10);
        hold = '1;
        drive_req();
        pulse_go();
        wait_blocks(10, 40);
        core_solved = 4'b0100;
        set_key(2, 24'h0A1B2C);
        tick();
        check("sol_found", 32'(found), 32'd1);
        check("sol_stop", 32'(stop_all), 32'd1);
        check("sol_key", 32'(found_key), 32'h0A1B2C);
        check("sol_core", 32'(found_core), 32'd2);
        check("sol_no_grant", 32'(core_grant), 32'd0);
        repeat (3) tick();
        check("sol_blocks", 32'(blocks_issued), 32'd10);
        check("sol_queue", 32'(exp_q.size()), 32'd0);

        // Simultaneous solutions, restarted from FOUND
        core_solved = '0;
        hold        = '0;
        drive_req();
        pulse_go();
        check("restart_found_clr", 32'(found), 32'd0);
        check("restart_key_clr", 32'(found_key), 32'd0);
        check("restart2_busy", 32'(busy), 32'd1);
        core_solved = 4'b1010;
        set_key(1, 24'h111111);
        set_key(3, 24'h333333);
        tick();
        check("dual_found", 32'(found), 32'd1);
        check("dual_key", 32'(found_key), 32'h111111);
        check("dual_core", 32'(found_core), 32'd1);
        core_solved = 4'b0001;
        set_key(0, 24'h000777);
        repeat (2) tick();
        check("frozen_key", 32'(found_key), 32'h111111);
        check("frozen_core", 32'(found_core), 32'd1);
        core_solved = '0;

        // Solve coinciding with the 64th grant candidate
        do_reset();
        push_rr(63);
        hold = '1;
        drive_req();
        pulse_go();
        wait_blocks(63, 200);
        core_solved = 4'b1000;
        set_key(3, 24'h3ABCDE);
        tick();
        check("last_found", 32'(found), 32'd1);
        check("last_no_grant", 32'(core_grant), 32'd0);
        check("last_blocks", 32'(blocks_issued), 32'd63);
        check("last_not_exh", 32'(exhausted), 32'd0);
        check("last_key", 32'(found_key), 32'h3ABCDE);
        check("last_core", 32'(found_core), 32'd3);
        core_solved = '0;
        hold        = '0;
        drive_req();
        tick();

        // Reset mid-RUN after 5 grants
        do_reset();
        push_rr(5);
        hold = '1;
        drive_req();
        pulse_go();
        wait_blocks(5, 20);
        reset_n = 1'b0;
        hold    = '0;
        drive_req();
        tick();
        check_all_zero("midreset");
        reset_n = 1'b1;
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        push_exp(0, 0);
        hold = 4'b0001;
        drive_req();
        pulse_go();
        wait_blocks(1, 10);
        hold = '0;
        drive_req();
        repeat (2) tick();
        check("after_reset_queue", 32'(exp_q.size()), 32'd0);
        check("after_reset_blocks", 32'(blocks_issued), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
